// File: rtl/snake_pkg.sv
// Shared snake-game types: direction encodings, default grid size and the
// coordinate pair used by the FSM, renderer and fruit generator.
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam int GRID_W_DEF    = 40;
    localparam int GRID_H_DEF    = 30;
    localparam int COORD_BIT_DEF = 7;

    typedef struct packed {
        logic [COORD_BIT_DEF-1:0] x;
        logic [COORD_BIT_DEF-1:0] y;
    } coord_t;

    typedef enum logic {
        ST_IDLE,
        ST_CHECK
    } snake_state_e;

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculation. With SNAKE_WRAP_EN defined, moves off
// an edge wrap to the opposite edge; otherwise they are flagged as off_grid.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int COORD_BIT = 7,
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF
) (
    input  logic [COORD_BIT-1:0] head_x,
    input  logic [COORD_BIT-1:0] head_y,
    input  logic [1:0]           dir,
    output logic [COORD_BIT-1:0] next_x,
    output logic [COORD_BIT-1:0] next_y,
    output logic                 off_grid
);

    localparam logic [COORD_BIT-1:0] X_MAX = COORD_BIT'(GRID_W - 1);
    localparam logic [COORD_BIT-1:0] Y_MAX = COORD_BIT'(GRID_H - 1);
    localparam logic [COORD_BIT-1:0] ONE   = COORD_BIT'(1);

    always_comb begin
        next_x   = head_x;
        next_y   = head_y;
        off_grid = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                if (head_x >= X_MAX) begin
`ifdef SNAKE_WRAP_EN
                    next_x = '0;
`else
                    off_grid = 1'b1;
`endif
                end else begin
                    next_x = head_x + ONE;
                end
            end
            DIR_LEFT: begin
                if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_x = X_MAX;
`else
                    off_grid = 1'b1;
`endif
                end else begin
                    next_x = head_x - ONE;
                end
            end
            DIR_UP: begin
                if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_y = Y_MAX;
`else
                    off_grid = 1'b1;
`endif
                end else begin
                    next_y = head_y - ONE;
                end
            end
            default: begin
                if (head_y >= Y_MAX) begin
`ifdef SNAKE_WRAP_EN
                    next_y = '0;
`else
                    off_grid = 1'b1;
`endif
                end else begin
                    next_y = head_y + ONE;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_body_buffer.sv
// Circular segment store for the snake body with a serial self-collision scan.
// SNAKE_WRAP_EN selects edge wrap-around instead of wall collision.
module snake_body_buffer
    import snake_pkg::*;
#(
    parameter int COORD_BIT        = 7,
    parameter int SNAKE_LENGTH_BIT = 4,
    parameter int GRID_W           = GRID_W_DEF,
    parameter int GRID_H           = GRID_H_DEF,
    parameter int INIT_LENGTH      = 3,
    parameter int INIT_X           = 20,
    parameter int INIT_Y           = 15
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        step,
    input  logic                        grow,
    input  logic [1:0]                  dir,
    input  logic [SNAKE_LENGTH_BIT-1:0] rd_index,
    output logic [COORD_BIT-1:0]        rd_x,
    output logic [COORD_BIT-1:0]        rd_y,
    output logic                        rd_valid,
    output logic [COORD_BIT-1:0]        snake_head_x,
    output logic [COORD_BIT-1:0]        snake_head_y,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic                        busy,
    output logic                        full,
    output logic                        self_collision,
    output logic                        wall_collision
);

    localparam int DEPTH = 2 ** SNAKE_LENGTH_BIT;

    typedef logic [SNAKE_LENGTH_BIT-1:0] idx_t;
    typedef logic [COORD_BIT-1:0]        crd_t;

    localparam idx_t MAX_LEN  = idx_t'(DEPTH - 1);
    localparam idx_t INIT_LEN = idx_t'(INIT_LENGTH);
    localparam idx_t ONE      = idx_t'(1);

    snake_state_e state_q, state_d;
    crd_t  mem_x_q [DEPTH];
    crd_t  mem_x_d [DEPTH];
    crd_t  mem_y_q [DEPTH];
    crd_t  mem_y_d [DEPTH];
    idx_t  head_ptr_q, head_ptr_d;
    idx_t  len_q, len_d;
    idx_t  scan_q, scan_d;
    crd_t  head_x_q, head_x_d;
    crd_t  head_y_q, head_y_d;
    logic  self_q, self_d;
    logic  wall_q, wall_d;
    crd_t  rd_x_q, rd_x_d;
    crd_t  rd_y_q, rd_y_d;
    logic  rd_valid_q, rd_valid_d;

    crd_t  next_x, next_y;
    logic  off_grid;
    idx_t  scan_addr, rd_addr;

    snake_next_head #(
        .COORD_BIT (COORD_BIT),
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H)
    ) u_next_head (
        .head_x   (head_x_q),
        .head_y   (head_y_q),
        .dir      (dir),
        .next_x   (next_x),
        .next_y   (next_y),
        .off_grid (off_grid)
    );

    always_comb begin
        state_d    = state_q;
        mem_x_d    = mem_x_q;
        mem_y_d    = mem_y_q;
        head_ptr_d = head_ptr_q;
        len_d      = len_q;
        scan_d     = scan_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        self_d     = self_q;
        wall_d     = wall_q;
        scan_addr  = head_ptr_q + scan_q;

        case (state_q)
            ST_IDLE: begin
                if (step && !self_q && !wall_q) begin
                    if (off_grid) begin
                        wall_d = 1'b1;
                    end else begin
                        // New head goes one slot before the old head; when not
                        // growing, the old tail simply falls outside the length.
                        head_ptr_d          = head_ptr_q - ONE;
                        mem_x_d[head_ptr_d] = next_x;
                        mem_y_d[head_ptr_d] = next_y;
                        head_x_d            = next_x;
                        head_y_d            = next_y;
                        if (grow && (len_q != MAX_LEN)) begin
                            len_d = len_q + ONE;
                        end
                        if (len_d > ONE) begin
                            state_d = ST_CHECK;
                            scan_d  = ONE;
                        end
                    end
                end
            end
            default: begin
                if ((mem_x_q[scan_addr] == head_x_q) && (mem_y_q[scan_addr] == head_y_q)) begin
                    self_d = 1'b1;
                end
                if (scan_q == len_q - ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    scan_d = scan_q + ONE;
                end
            end
        endcase

        // Reads see this edge's step update, so index 0 always means the new head.
        rd_addr    = head_ptr_d + rd_index;
        rd_valid_d = (rd_index < len_d);
        rd_x_d     = rd_valid_d ? mem_x_d[rd_addr] : '0;
        rd_y_d     = rd_valid_d ? mem_y_d[rd_addr] : '0;
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            head_ptr_q <= '0;
            len_q      <= INIT_LEN;
            scan_q     <= ONE;
            head_x_q   <= crd_t'(INIT_X);
            head_y_q   <= crd_t'(INIT_Y);
            self_q     <= 1'b0;
            wall_q     <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_valid_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_x_q[k] <= (k < INIT_LENGTH) ? crd_t'(INIT_X - k) : '0;
                mem_y_q[k] <= (k < INIT_LENGTH) ? crd_t'(INIT_Y) : '0;
            end
        end else begin
            state_q    <= state_d;
            head_ptr_q <= head_ptr_d;
            len_q      <= len_d;
            scan_q     <= scan_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            self_q     <= self_d;
            wall_q     <= wall_d;
            rd_x_q     <= rd_x_d;
            rd_y_q     <= rd_y_d;
            rd_valid_q <= rd_valid_d;
            mem_x_q    <= mem_x_d;
            mem_y_q    <= mem_y_d;
        end
    end

    assign rd_x           = rd_x_q;
    assign rd_y           = rd_y_q;
    assign rd_valid       = rd_valid_q;
    assign snake_head_x   = head_x_q;
    assign snake_head_y   = head_y_q;
    assign snake_length   = len_q;
    assign busy           = (state_q == ST_CHECK);
    assign full           = (len_q == MAX_LEN);
    assign self_collision = self_q;
    assign wall_collision = wall_q;

endmodule
